// File: rtl/turn_input_conditioner_pkg.sv
// Shared constants for the turn-button conditioner: turn encoding, key FSM states, debounce defaults.
package turn_input_conditioner_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;
    localparam int unsigned DEFAULT_DEB_CNT_BIT     = 18;

    localparam logic TURN_RIGHT = 1'b0;
    localparam logic TURN_LEFT  = 1'b1;

    localparam int unsigned QUEUE_CNT_BIT = 2;
    localparam logic [QUEUE_CNT_BIT-1:0] QUEUE_DEPTH = QUEUE_CNT_BIT'(2);

    typedef enum logic [1:0] {
        KEY_RELEASED    = 2'd0,
        KEY_PRESS_CHK   = 2'd1,
        KEY_PRESSED     = 2'd2,
        KEY_RELEASE_CHK = 2'd3
    } key_state_e;

endpackage

// File: rtl/turn_input_conditioner_key_debouncer.sv
// One push-button: 2-FF synchroniser, debounce counter and 4-state FSM.
// press_event_c is a one-cycle Mealy pulse on the debounced press transition.
module key_debouncer
    import turn_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned DEB_CNT_BIT     = DEFAULT_DEB_CNT_BIT
) (
    input  logic clock_25,
    input  logic reset,
    input  logic key_n,
    output logic press_event_c
);

    localparam logic [DEB_CNT_BIT-1:0] CNT_LAST = DEB_CNT_BIT'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_CNT_BIT-1:0] CNT_ONE  = DEB_CNT_BIT'(1);

    logic                   sync_q1;
    logic                   sync_q2;
    logic                   pressed_c;
    key_state_e             state_q;
    key_state_e             state_d;
    logic [DEB_CNT_BIT-1:0] cnt_q;
    logic [DEB_CNT_BIT-1:0] cnt_d;

    // Synchroniser idles at the released (high) level
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= key_n;
            sync_q2 <= sync_q1;
        end
    end

    assign pressed_c = ~sync_q2;

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            state_q <= KEY_RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        press_event_c = 1'b0;
        case (state_q)
            KEY_RELEASED: begin
                if (pressed_c) begin
                    state_d = KEY_PRESS_CHK;
                    cnt_d   = '0;
                end
            end
            KEY_PRESS_CHK: begin
                if (!pressed_c) begin
                    state_d = KEY_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = KEY_PRESSED;
                    cnt_d         = '0;
                    press_event_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            KEY_PRESSED: begin
                if (!pressed_c) begin
                    state_d = KEY_RELEASE_CHK;
                    cnt_d   = '0;
                end
            end
            KEY_RELEASE_CHK: begin
                if (pressed_c) begin
                    state_d = KEY_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = KEY_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = KEY_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/turn_input_conditioner.sv
// Debounces the two turn buttons and buffers press events in a 2-entry turn queue
// consumed one entry per game_tik.
module turn_input_conditioner
    import turn_input_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned DEB_CNT_BIT     = DEFAULT_DEB_CNT_BIT
) (
    input  logic                     clock_25,
    input  logic                     reset,
    input  logic                     key_right_n,
    input  logic                     key_left_n,
    input  logic                     game_tik,
    input  logic                     sync_reset,
    output logic                     right_P,
    output logic                     left_P,
    output logic [QUEUE_CNT_BIT-1:0] queue_count,
    output logic                     overflow
);

    localparam logic [QUEUE_CNT_BIT-1:0] CNT_ONE = QUEUE_CNT_BIT'(1);

    logic                     right_event_c;
    logic                     left_event_c;
    logic [1:0]               slot_q;
    logic [1:0]               slot_d;
    logic                     head_q;
    logic                     head_d;
    logic [QUEUE_CNT_BIT-1:0] count_d;
    logic                     right_d;
    logic                     left_d;
    logic                     overflow_d;
    logic                     push_c;
    logic                     pop_c;
    logic                     turn_in_c;
    logic                     wr_idx_c;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEB_CNT_BIT     (DEB_CNT_BIT)
    ) u_right_key (
        .clock_25      (clock_25),
        .reset         (reset),
        .key_n         (key_right_n),
        .press_event_c (right_event_c)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DEB_CNT_BIT     (DEB_CNT_BIT)
    ) u_left_key (
        .clock_25      (clock_25),
        .reset         (reset),
        .key_n         (key_left_n),
        .press_event_c (left_event_c)
    );

    // Next queue state; simultaneous events on both keys are ambiguous and never pushed
    always_comb begin
        slot_d     = slot_q;
        head_d     = head_q;
        count_d    = queue_count;
        overflow_d = 1'b0;
        push_c     = right_event_c ^ left_event_c;
        turn_in_c  = left_event_c ? TURN_LEFT : TURN_RIGHT;
        pop_c      = game_tik && (queue_count != '0);
        wr_idx_c   = head_q ^ queue_count[0];

        if (sync_reset) begin
            count_d = '0;
            head_d  = 1'b0;
        end else begin
            if (pop_c) begin
                head_d  = ~head_q;
                count_d = queue_count - CNT_ONE;
            end
            if (push_c) begin
                if ((queue_count == QUEUE_DEPTH) && !pop_c) begin
                    overflow_d = 1'b1;
                end else begin
                    slot_d[wr_idx_c] = turn_in_c;
                    count_d          = count_d + CNT_ONE;
                end
            end
        end

        right_d = (count_d != '0) && (slot_d[head_d] == TURN_RIGHT);
        left_d  = (count_d != '0) && (slot_d[head_d] == TURN_LEFT);
    end

    // Head outputs are registered alongside the queue so they never glitch
    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            slot_q      <= '0;
            head_q      <= 1'b0;
            queue_count <= '0;
            right_P     <= 1'b0;
            left_P      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            head_q      <= head_d;
            queue_count <= count_d;
            right_P     <= right_d;
            left_P      <= left_d;
            overflow    <= overflow_d;
        end
    end

endmodule

// File: tb/tb_turn_input_conditioner.sv
// Randomised + directed bench; a run-length debounce model and a queue model predict outputs each cycle.
module tb_turn_input_conditioner;

    localparam int unsigned DEB = 4;

    typedef struct packed {
        logic       rp;
        logic       lp;
        logic [1:0] cnt;
        logic       ovf;
    } obs_t;

    logic       clock_25 = 1'b0;
    logic       reset = 1'b1;
    logic       key_right_n = 1'b1;
    logic       key_left_n = 1'b1;
    logic       game_tik = 1'b0;
    logic       sync_reset = 1'b0;
    logic       right_P;
    logic       left_P;
    logic [1:0] queue_count;
    logic       overflow;

    int vectors = 0;
    int miscompares = 0;

    obs_t exp_q[$];

    // Model state: two-stage delayed pressed level, debounced level, run length of disagreement
    bit   s1[2];
    bit   s2[2];
    bit   deb[2];
    int   run[2];
    bit   turns[$];

    turn_input_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .DEB_CNT_BIT     (3)
    ) dut (
        .clock_25    (clock_25),
        .reset       (reset),
        .key_right_n (key_right_n),
        .key_left_n  (key_left_n),
        .game_tik    (game_tik),
        .sync_reset  (sync_reset),
        .right_P     (right_P),
        .left_P      (left_P),
        .queue_count (queue_count),
        .overflow    (overflow)
    );

    always #5 clock_25 = ~clock_25;

    task automatic model_edge();
        bit   ev[2];
        bit   raw[2];
        bit   ovf;
        obs_t e;
        ovf    = 1'b0;
        raw[0] = !key_right_n;
        raw[1] = !key_left_n;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                s1[k] = 0; s2[k] = 0; deb[k] = 0; run[k] = 0;
            end
            turns.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                ev[k] = 0;
                // A level is accepted after DEB+1 consecutive disagreeing samples
                if (s2[k] != deb[k]) begin
                    run[k]++;
                    if (run[k] == DEB + 1) begin
                        deb[k] = s2[k];
                        run[k] = 0;
                        ev[k]  = deb[k];
                    end
                end else begin
                    run[k] = 0;
                end
                s2[k] = s1[k];
                s1[k] = raw[k];
            end
            if (sync_reset) begin
                turns.delete();
            end else begin
                bit had = (turns.size() > 0);
                if (game_tik && had) void'(turns.pop_front());
                if (ev[0] != ev[1]) begin
                    if (turns.size() < 2) turns.push_back(ev[1]);
                    else ovf = 1'b1;
                end
            end
        end
        e.cnt = 2'(turns.size());
        e.rp  = (turns.size() > 0) && (turns[0] == 1'b0);
        e.lp  = (turns.size() > 0) && (turns[0] == 1'b1);
        e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clock_25);
            model_edge();
        end
    end

    // Monitor: one registered observation per cycle, compared on the falling edge
    initial begin
        forever begin
            obs_t got;
            obs_t want;
            @(negedge clock_25);
            got = '{rp: right_P, lp: left_P, cnt: queue_count, ovf: overflow};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty t=%0t got=%b", $time, got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t got rP=%b lP=%b cnt=%0d ovf=%b want rP=%b lP=%b cnt=%0d ovf=%b",
                             $time, got.rp, got.lp, got.cnt, got.ovf, want.rp, want.lp, want.cnt, want.ovf);
                end
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock_25);
            #1;
        end
    endtask

    task automatic press(input bit left, input int hold, input int rel);
        if (left) key_left_n = 1'b0; else key_right_n = 1'b0;
        step(hold);
        key_left_n  = 1'b1;
        key_right_n = 1'b1;
        step(rel);
    endtask

    task automatic tik();
        game_tik = 1'b1;
        step(1);
        game_tik = 1'b0;
        step(2);
    endtask

    initial begin
        step(3);
        reset = 1'b0;
        step(2);

        // Single right press, then consume it
        press(1'b0, 10, 12);
        tik();

        // Bouncing left, then a stable hold
        for (int i = 0; i < 2; i++) begin
            key_left_n = 1'b0; step(2);
            key_left_n = 1'b1; step(2);
        end
        press(1'b1, 10, 12);
        tik();

        // Fill, overflow, drain
        press(1'b0, 8, 12);
        press(1'b1, 8, 12);
        press(1'b0, 8, 12);
        tik();
        tik();

        // Full queue while game_tik coincides with a new left event
        press(1'b0, 8, 12);
        press(1'b0, 8, 12);
        key_left_n = 1'b0;
        step(6);
        game_tik = 1'b1;
        step(1);
        game_tik = 1'b0;
        step(4);
        key_left_n = 1'b1;
        step(12);

        // Both keys qualify together
        key_left_n  = 1'b0;
        key_right_n = 1'b0;
        step(10);
        key_left_n  = 1'b1;
        key_right_n = 1'b1;
        step(12);

        // Async reset in the middle of a right press check, key kept held
        key_right_n = 1'b0;
        step(4);
        reset = 1'b1;
        #1;
        vectors++;
        if ({right_P, left_P, queue_count, overflow} !== 5'b0) begin
            miscompares++;
            $display("FAIL async_reset got=%b want=00000", {right_P, left_P, queue_count, overflow});
        end
        step(2);
        reset = 1'b0;
        step(10);
        key_right_n = 1'b1;
        step(12);

        // Refill then flush
        press(1'b1, 8, 12);
        sync_reset = 1'b1;
        step(1);
        sync_reset = 1'b0;
        step(3);

        // Random phase
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0) key_right_n = ~key_right_n;
            if ($urandom_range(7) == 0) key_left_n  = ~key_left_n;
            game_tik   = ($urandom_range(5) == 0);
            sync_reset = ($urandom_range(199) == 0);
            step(1);
        end
        game_tik   = 1'b0;
        sync_reset = 1'b0;
        step(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
